// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

    // Scheduler sequencing: pick a byte, strobe it, then track uart_tx busy.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LAUNCH     = 2'd1,
        WAIT_START = 2'd2,
        WAIT_END   = 2'd3
    } state_t;

    // Which source owns the byte currently in flight.
    typedef enum logic [1:0] {
        SRC_HDR = 2'd0,
        SRC_CMD = 2'd1,
        SRC_PIX = 2'd2
    } src_t;

    localparam logic [7:0] DEFAULT_HDR_BYTE = 8'hA5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read: rd_data always shows
// the oldest entry while empty is low. Writes into a full FIFO and reads from
// an empty FIFO are ignored. A read in the same cycle does not free space for
// that cycle's write because full is evaluated before the pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // The extra pointer bit distinguishes full from empty when indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer control; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx between the frame header, host cmd/status bytes and the
// buffered Sobel pixel stream. One byte is in flight at a time: a byte is
// strobed, then the scheduler waits for busy to rise and fall before it
// arbitrates again. Header always wins; cmd and pixel alternate round-robin.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 16,
    parameter int         FRAME_PIXELS = 4096,
    parameter logic [7:0] HDR_BYTE     = DEFAULT_HDR_BYTE,
    parameter int         START_TO     = 15
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ack,
    input  logic       tx_flag,
    output logic       tx_po_flag,
    output logic [7:0] tx_po_data,
    output logic       frame_done,
    output logic       fifo_ovf,
    output logic       tx_err
);

    localparam logic [15:0] LAST_PIX = 16'(FRAME_PIXELS - 1);
    localparam logic [15:0] TO_LAST  = 16'(START_TO - 1);

    state_t      state;
    src_t        src;
    logic        hdr_pend;
    logic        rr;
    logic [15:0] pix_cnt;
    logic [15:0] timer;

    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_rd_data;
    logic        cmd_win;
    logic        pix_win;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sclk),
        .rst     (rst),
        .wr_en   (pix_valid),
        .wr_data (pix_data),
        .rd_en   (pix_win),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign pix_ready = !fifo_full;
    assign cmd_ack   = cmd_win;

    // Cmd/pixel arbitration in IDLE once no header is pending; rr picks the
    // favoured side only when both are requesting.
    always_comb begin
        cmd_win = 1'b0;
        pix_win = 1'b0;
        if (state == IDLE && !hdr_pend) begin
            if (cmd_valid && (fifo_empty || !rr)) begin
                cmd_win = 1'b1;
            end else if (!fifo_empty) begin
                pix_win = 1'b1;
            end
        end
    end

    // Scheduler FSM with registered strobe, byte, frame and error flags.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state      <= IDLE;
            src        <= SRC_HDR;
            hdr_pend   <= 1'b0;
            rr         <= 1'b0;
            pix_cnt    <= '0;
            timer      <= '0;
            tx_po_flag <= 1'b0;
            tx_po_data <= '0;
            frame_done <= 1'b0;
            fifo_ovf   <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            tx_po_flag <= 1'b0;
            frame_done <= 1'b0;

            if (pix_valid && fifo_full) fifo_ovf <= 1'b1;

            case (state)
                IDLE: begin
                    if (hdr_pend) begin
                        tx_po_data <= HDR_BYTE;
                        src        <= SRC_HDR;
                        hdr_pend   <= 1'b0;
                        tx_po_flag <= 1'b1;
                        state      <= LAUNCH;
                    end else if (cmd_win) begin
                        tx_po_data <= cmd_data;
                        src        <= SRC_CMD;
                        rr         <= !rr;
                        tx_po_flag <= 1'b1;
                        state      <= LAUNCH;
                    end else if (pix_win) begin
                        tx_po_data <= fifo_rd_data;
                        src        <= SRC_PIX;
                        rr         <= !rr;
                        tx_po_flag <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    // timer counts cycles since the strobe cycle
                    timer <= 16'd1;
                    state <= WAIT_START;
                end
                WAIT_START: begin
                    if (tx_flag) begin
                        state <= WAIT_END;
                    end else if (timer >= TO_LAST) begin
                        // uart_tx never accepted the byte; drop it
                        tx_err <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                WAIT_END: begin
                    if (!tx_flag) begin
                        state <= IDLE;
                        if (src == SRC_PIX) begin
                            if (pix_cnt == LAST_PIX) begin
                                frame_done <= 1'b1;
                                pix_cnt    <= '0;
                            end else begin
                                pix_cnt <= pix_cnt + 16'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A new frame always re-arms the header, even against a grant in
            // the same cycle, and restarts the pixel count.
            if (frame_start) begin
                hdr_pend <= 1'b1;
                pix_cnt  <= '0;
            end
        end
    end

endmodule
